uart_tx_frmr: RTL and testbench
===============================

// Module: uart_tx_frmr
// PURPOSE
//  Parametrised UART transmit framer; successor to the fixed 8-bit serializer.
//  Run-time frame format: 5..MAX_WORD_WIDTH data bits, none/even/odd parity, 1 or 2 stop bits.
//  Takes words over a valid/ready handshake and drives the TX pin, LSB first, one bit per OVERSAMPLING baud ticks.
//  Sits between the TX FIFO and the pad, clocked by the shared baud tick generator.
// PARAMETERS
//  MAX_WORD_WIDTH  9   widest supported data field; legal range 5..9
//  OVERSAMPLING    16  baud ticks per bit time; >=2
// PORTS
//  clk             in   1    system clock
//  rst             in   1    synchronous, active-high reset
//  tick            in   1    baud-tick strobe, 1 clk wide
//  din             in   MAX_WORD_WIDTH  data word; bits above cfg_data_bits ignored
//  din_valid       in   1    din holds a word to send
//  din_ready       out  1    framer can accept a word
//  cfg_data_bits   in   4    data bits per frame, 5..MAX_WORD_WIDTH
//  cfg_parity_en   in   1    1 = append parity bit
//  cfg_parity_odd  in   1    1 = odd parity, 0 = even
//  cfg_stop2       in   1    1 = two stop bits, 0 = one
//  dout            out  1    serial line; idles high
//  active          out  1    frame in progress (state != IDLE)
//  tx_done         out  1    1-cycle pulse when the last stop bit completes
// BEHAVIOUR
//  - Single clock domain, clk. Reset is synchronous and active-high on rst; it overrides all other inputs.
//  - Reset values: state IDLE, dout=1 (registered), din_ready=1, active=0, tx_done=0, counters 0.
//  - States:
//    - IDLE -> START on accept.
//    - START -> DATA.
//    - DATA -> PARITY when cfg_parity_en, else -> STOP.
//    - PARITY -> STOP.
//    - STOP -> IDLE after 1 or 2 bit times.
//  - din_ready = (state==IDLE). Accept = din_valid & din_ready.
//  - On accept: latch din, all cfg_* fields and the computed parity bit.
//    - cfg_* changes during a frame have no effect until the next accept.
//  - cfg_data_bits clamp at accept: <5 uses 5; >MAX_WORD_WIDTH uses MAX_WORD_WIDTH.
//  - Parity covers the N active data bits only.
//    - even: bit = XOR(data); odd: bit = ~XOR(data).
//  - dout is registered and reflects the current state.
//    - START drives 0; DATA drives the current LSB; PARITY drives the parity bit; STOP and IDLE drive 1.
//  - Latency: dout falls on the clk edge after the accept cycle.
//  - Bit timing:
//    - The tick counter loads OVERSAMPLING-1 on accept and on each bit boundary.
//    - Each tick decrements the counter.
//    - A tick seen with the counter at 0 ends the bit.
//    - A tick coinciding with the accept cycle is ignored.
//    - Every bit lasts exactly OVERSAMPLING ticks.
//  - DATA: shift the latched word right once per bit; exactly N bits are sent.
//  - STOP: lasts 1 or 2 full bit times. On its final tick: tx_done=1 for that cycle, state -> IDLE.
//  - Back-to-back: din_ready rises the cycle after tx_done; a held din_valid is accepted then.
//    The line stays high for at least 1 clk between frames.
//  - Frame length (ticks) = OVERSAMPLING*(1+N+P+S), where P is the parity bit (0/1) and S the stop bits (1/2).
//  - rst mid-frame: next clk returns to IDLE with dout=1; no tx_done; the partial word is dropped.
// TESTING
//  - OVERSAMPLING=16, tick every clk, 8N1, din=0xA5.
//    -> dout: 0,1,0,1,0,0,1,0,1,1, each 16 clks; tx_done after 160 ticks.
//  - 8E1, din=0xA5 (four 1s) -> parity bit 0; frame 176 ticks.
//  - 7O2, din=0x41 (two 1s) -> data 1,0,0,0,0,0,1, then parity 1, then 2 stop bits; frame 176 ticks.
//  - din_valid held, words 0x12 then 0x34, 8N1.
//    -> din_ready low across frame 1; word 2 accepted the cycle after tx_done; both frames correct.
//  - Assert rst during the 3rd data bit -> dout=1, active=0, din_ready=1 next clk; no tx_done.
//  - Edge cases, each with tick every 4 clks:
//    - cfg_data_bits=3 -> 5 data bits sent, each bit 64 clks.
//    - cfg change mid-frame -> frame format unaffected.

Source files
------------

// File: rtl/uart_tx_frmr.sv
// UART transmit framer: run-time 5..MAX_WORD_WIDTH data bits, optional even/odd parity,
// 1 or 2 stop bits, LSB first, one bit per OVERSAMPLING baud ticks.
module uart_tx_frmr #(
  parameter int MAX_WORD_WIDTH = 9,
  parameter int OVERSAMPLING   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic [MAX_WORD_WIDTH-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [3:0]                cfg_data_bits,
  input  logic                      cfg_parity_en,
  input  logic                      cfg_parity_odd,
  input  logic                      cfg_stop2,
  output logic                      dout,
  output logic                      active,
  output logic                      tx_done
);

  localparam int                CW      = $clog2(OVERSAMPLING);
  localparam logic [CW-1:0]     CNT_TOP = CW'(OVERSAMPLING - 1);
  localparam logic [3:0]        MAXW4   = 4'(MAX_WORD_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                    state_q, state_n;
  logic [MAX_WORD_WIDTH-1:0] shreg_q, shreg_n;
  logic [CW-1:0]             cnt_q, cnt_n;
  logic [3:0]                bits_q, bits_n;
  logic                      par_en_q, par_en_n;
  logic                      par_bit_q, par_bit_n;
  logic                      stop2_q, stop2_n;
  logic                      dout_q, dout_n;
  logic                      tx_done_c;
  logic                      bit_end;
  logic [3:0]                n_eff;
  logic [MAX_WORD_WIDTH-1:0] word_m;

  // Clamp the requested width and blank data bits that are not sent, so parity sees only live bits.
  always_comb begin
    n_eff = cfg_data_bits;
    if (cfg_data_bits < 4'd5)        n_eff = 4'd5;
    else if (cfg_data_bits > MAXW4)  n_eff = MAXW4;
    for (int i = 0; i < MAX_WORD_WIDTH; i++)
      word_m[i] = din[i] & (i < int'(n_eff));
  end

  always_comb begin
    state_n   = state_q;
    shreg_n   = shreg_q;
    cnt_n     = cnt_q;
    bits_n    = bits_q;
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
    stop2_n   = stop2_q;
    tx_done_c = 1'b0;
    dout_n    = 1'b1;
    bit_end   = tick && (cnt_q == '0);

    if (state_q != S_IDLE && tick)
      cnt_n = bit_end ? CNT_TOP : cnt_q - CW'(1);

    // bits_q counts remaining data bits in DATA and remaining stop bits in STOP.
    case (state_q)
      S_IDLE: if (din_valid) begin
        state_n   = S_START;
        shreg_n   = word_m;
        bits_n    = n_eff - 4'd1;
        cnt_n     = CNT_TOP;
        par_en_n  = cfg_parity_en;
        par_bit_n = (^word_m) ^ cfg_parity_odd;
        stop2_n   = cfg_stop2;
      end
      S_START: if (bit_end) state_n = S_DATA;
      S_DATA: if (bit_end) begin
        shreg_n = shreg_q >> 1;
        if (bits_q == 4'd0) begin
          state_n = par_en_q ? S_PARITY : S_STOP;
          bits_n  = {3'b000, stop2_q};
        end else begin
          bits_n = bits_q - 4'd1;
        end
      end
      S_PARITY: if (bit_end) begin
        state_n = S_STOP;
        bits_n  = {3'b000, stop2_q};
      end
      S_STOP: if (bit_end) begin
        if (bits_q == 4'd0) begin
          state_n   = S_IDLE;
          tx_done_c = 1'b1;
        end else begin
          bits_n = bits_q - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Line level is registered from the state being entered.
    case (state_n)
      S_START:  dout_n = 1'b0;
      S_DATA:   dout_n = shreg_n[0];
      S_PARITY: dout_n = par_bit_n;
      default:  dout_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      bits_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      dout_q    <= 1'b1;
    end else begin
      state_q   <= state_n;
      shreg_q   <= shreg_n;
      cnt_q     <= cnt_n;
      bits_q    <= bits_n;
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
      stop2_q   <= stop2_n;
      dout_q    <= dout_n;
    end
  end

  assign din_ready = (state_q == S_IDLE);
  assign active    = (state_q != S_IDLE);
  assign dout      = dout_q;
  assign tx_done   = tx_done_c & ~rst;

endmodule

// File: tb/tb_uart_tx_frmr.sv
// Bench for uart_tx_frmr: table vectors, back-to-back, mid-frame reset and random frames
// checked against a bit-list model of the frame format.
module tb_uart_tx_frmr;
  localparam int MW = 9;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [MW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [3:0]    cfg_data_bits = 4'd8;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_odd = 1'b0;
  logic          cfg_stop2 = 1'b0;
  logic          dout, active, tx_done;

  int checks = 0;
  int errors = 0;
  int tick_per = 1;
  int free_cnt = 0;

  uart_tx_frmr #(.MAX_WORD_WIDTH(MW), .OVERSAMPLING(OS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2), .dout(dout),
    .active(active), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      free_cnt = free_cnt + 1;
      tick = (tick_per <= 1) ? 1'b1 : ((free_cnt % tick_per) == 0);
    end
  end

  typedef struct {
    logic [8:0]  d;
    logic [3:0]  nb;
    logic        pe, po, s2;
    int          tper;
    bit          scr;
    logic [15:0] pat;
    int          nbits;
    int          len;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Frame as a list of line levels: start, N data bits, optional parity, stop bits.
  function automatic void model(input logic [8:0] d, input logic [3:0] nb_cfg, input logic pe,
                                input logic po, input logic s2, output logic [15:0] pat,
                                output int nbits);
    int n;
    int ones;
    int idx;
    n = (int'(nb_cfg) < 5) ? 5 : ((int'(nb_cfg) > MW) ? MW : int'(nb_cfg));
    pat = '0;
    ones = 0;
    idx = 1;
    for (int i = 0; i < n; i++) begin
      pat[idx] = d[i];
      ones += int'(d[i]);
      idx++;
    end
    if (pe) begin
      pat[idx] = ((ones % 2) == 1) ^ po;
      idx++;
    end
    pat[idx] = 1'b1;
    idx++;
    if (s2) begin
      pat[idx] = 1'b1;
      idx++;
    end
    nbits = idx;
  endfunction

  task automatic run_frame(input logic [8:0] d, input logic [3:0] nb, input logic pe,
                           input logic po, input logic s2, input bit scr, input bit hold,
                           input logic [8:0] next_d, output logic [15:0] pat, output int len,
                           output int waited, output bit ok_hs, output bit ok_stable,
                           output int bitclks, output logic idle_dout);
    int k, cyc, done_at, b1c, b2c, b;
    din = d; cfg_data_bits = nb; cfg_parity_en = pe; cfg_parity_odd = po; cfg_stop2 = s2;
    din_valid = 1'b1;
    waited = 0;
    pat = '0; len = 0; ok_hs = 1'b1; ok_stable = 1'b1; bitclks = 0;
    while (!din_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    idle_dout = dout;
    if (!din_ready) begin
      ok_hs = 1'b0;
      din_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #2;
    din_valid = hold;
    din = hold ? next_d : 9'($urandom);
    if (scr) begin
      cfg_data_bits = 4'($urandom); cfg_parity_en = ~pe; cfg_parity_odd = ~po; cfg_stop2 = ~s2;
    end
    k = 0; cyc = 0; done_at = -1; b1c = 0; b2c = 0;
    while (done_at < 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (din_ready || !active) ok_hs = 1'b0;
      if (tx_done && !tick) begin
        ok_hs = 1'b0;
        done_at = k;
      end else if (tick) begin
        b = k / OS;
        if (b < 16) begin
          if ((k % OS) == 0) begin
            pat[b] = dout;
            if (b == 1) b1c = cyc;
            if (b == 2) b2c = cyc;
          end else if (dout != pat[b]) begin
            ok_stable = 1'b0;
          end
        end
        if (tx_done) done_at = k;
        k++;
      end
    end
    len = done_at + 1;
    bitclks = b2c - b1c;
  endtask

  vec_t        tbl[5];
  logic [15:0] pat, epat;
  int          len, waited, bitclks, enb, dones, lows;
  bit          ok_hs, ok_st;
  logic        idle_d;
  logic [8:0]  rd;
  logic [3:0]  rnb;
  logic        rpe, rpo, rs2;

  initial begin
    tbl[0] = '{9'h0A5, 4'd8,  1'b0, 1'b0, 1'b0, 1, 1'b0, 16'h034A, 10, 160};
    tbl[1] = '{9'h0A5, 4'd8,  1'b1, 1'b0, 1'b0, 1, 1'b0, 16'h054A, 11, 176};
    tbl[2] = '{9'h041, 4'd7,  1'b1, 1'b1, 1'b1, 1, 1'b0, 16'h0782, 11, 176};
    tbl[3] = '{9'h1F6, 4'd3,  1'b0, 1'b0, 1'b0, 4, 1'b0, 16'h006C, 7,  112};
    tbl[4] = '{9'h155, 4'd15, 1'b1, 1'b0, 1'b1, 4, 1'b1, 16'h1EAA, 13, 208};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", int'(dout), 1);
    chk("rst_ready", int'(din_ready), 1);
    chk("rst_active", int'(active), 0);
    chk("rst_done", int'(tx_done), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      tick_per = tbl[i].tper;
      repeat (2) @(negedge clk);
      run_frame(tbl[i].d, tbl[i].nb, tbl[i].pe, tbl[i].po, tbl[i].s2, tbl[i].scr, 1'b0, 9'h0,
                pat, len, waited, ok_hs, ok_st, bitclks, idle_d);
      chk($sformatf("tbl%0d_pattern", i), int'(pat), int'(tbl[i].pat));
      chk($sformatf("tbl%0d_len", i), len, tbl[i].len);
      chk($sformatf("tbl%0d_nbits", i), len / OS, tbl[i].nbits);
      chk($sformatf("tbl%0d_handshake", i), int'(ok_hs), 1);
      chk($sformatf("tbl%0d_stable", i), int'(ok_st), 1);
      chk($sformatf("tbl%0d_bitclks", i), bitclks, OS * tbl[i].tper);
    end

    // Back-to-back with din_valid held through the first frame.
    tick_per = 1;
    repeat (2) @(negedge clk);
    run_frame(9'h012, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h034,
              pat, len, waited, ok_hs, ok_st, bitclks, idle_d);
    model(9'h012, 4'd8, 1'b0, 1'b0, 1'b0, epat, enb);
    chk("b2b1_pattern", int'(pat), int'(epat));
    chk("b2b1_len", len, enb * OS);
    chk("b2b1_handshake", int'(ok_hs), 1);
    run_frame(9'h034, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0,
              pat, len, waited, ok_hs, ok_st, bitclks, idle_d);
    model(9'h034, 4'd8, 1'b0, 1'b0, 1'b0, epat, enb);
    chk("b2b_wait", waited, 1);
    chk("b2b_gap_high", int'(idle_d), 1);
    chk("b2b2_pattern", int'(pat), int'(epat));
    chk("b2b2_len", len, enb * OS);

    // Reset during the third data bit.
    repeat (3) @(negedge clk);
    din = 9'h0A5; cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    din_valid = 1'b1;
    @(posedge clk);
    #2;
    din_valid = 1'b0;
    dones = 0;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      if (tx_done) dones++;
    end
    chk("mid_active", int'(active), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_dout", int'(dout), 1);
    chk("mid_rst_active", int'(active), 0);
    chk("mid_rst_ready", int'(din_ready), 1);
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_done) dones++;
      if (!dout) lows++;
    end
    chk("mid_rst_no_done", dones, 0);
    chk("mid_rst_line_idle", lows, 0);

    // Random frames against the model.
    for (int r = 0; r < 16; r++) begin
      rd = 9'($urandom); rnb = 4'($urandom_range(0, 15));
      rpe = 1'($urandom); rpo = 1'($urandom); rs2 = 1'($urandom);
      tick_per = $urandom_range(1, 3);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      run_frame(rd, rnb, rpe, rpo, rs2, 1'($urandom), 1'b0, 9'h0,
                pat, len, waited, ok_hs, ok_st, bitclks, idle_d);
      model(rd, rnb, rpe, rpo, rs2, epat, enb);
      chk($sformatf("rnd%0d_pattern", r), int'(pat), int'(epat));
      chk($sformatf("rnd%0d_len", r), len, enb * OS);
      chk($sformatf("rnd%0d_handshake", r), int'(ok_hs & ok_st), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
